// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator-based sort controller.
package cmp_pkg;

  // Value width, fixed by the 5-bit magnitude comparator.
  localparam int W = 5;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_res_t;

endpackage

// File: rtl/mag_cmp5.sv
// Combinational unsigned 5-bit magnitude comparator with one-hot result.
module mag_cmp5
  import cmp_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         a_eq_b,
  output logic         a_gt_b,
  output logic         a_lt_b
);

  // Exactly one of the three decisions is high for any input pair.
  always_comb begin
    a_eq_b = (a == b);
    a_gt_b = (a > b);
    a_lt_b = (a < b);
  end

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Loads N values, bubble-sorts them in place using one shared comparator
// (one compare per cycle), then streams them out in ascending order.
//
// state | meaning
// LOAD  | accepting N words on the input handshake
// SORT  | one compare/swap of mem[j], mem[j+1] per cycle
// DRAIN | presenting mem[rd] on the output handshake
module cmp_sort_ctrl
  import cmp_pkg::*;
#(
  parameter int N = 4,
  parameter int W = cmp_pkg::W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int IW = $clog2(N);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
  localparam logic [CW-1:0] LAST_J    = CW'(N - 2);
  localparam logic [CW-1:0] LAST_PASS = CW'(N - 2);

  // Elaboration-time configuration checks.
  if (W != 5) begin : g_bad_w
    $error("cmp_sort_ctrl: W must be 5 to match mag_cmp5");
  end
  if (N < 2 || N > 16) begin : g_bad_n
    $error("cmp_sort_ctrl: N must be in 2..16");
  end

  state_e          state_q, state_d;
  logic [W-1:0]    mem_q [N];
  logic [W-1:0]    mem_d [N];
  logic [CW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   j_q, j_d;
  logic [CW-1:0]   pass_q, pass_d;
  logic [CW-1:0]   rd_q, rd_d;
  logic            swapped_q, swapped_d;

  logic [IW-1:0]   idx_a, idx_b, idx_rd, idx_wr;
  logic [CW-1:0]   j_p1;
  cmp_res_t        cmp_res;

  // Read/write mux indices; counters never exceed N-1 where used as index.
  always_comb begin
    j_p1   = j_q + ONE;
    idx_a  = j_q[IW-1:0];
    idx_b  = j_p1[IW-1:0];
    idx_rd = rd_q[IW-1:0];
    idx_wr = wr_q[IW-1:0];
  end

  mag_cmp5 u_cmp (
    .a      (mem_q[idx_a]),
    .b      (mem_q[idx_b]),
    .a_eq_b (cmp_res.eq),
    .a_gt_b (cmp_res.gt),
    .a_lt_b (cmp_res.lt)
  );

  // Outputs decode directly from state so reset takes effect immediately.
  always_comb begin
    in_ready  = (state_q == LOAD);
    busy      = (state_q == SORT);
    out_valid = (state_q == DRAIN);
    out_last  = (state_q == DRAIN) && (rd_q == LAST_IDX);
    out_data  = (state_q == DRAIN) ? mem_q[idx_rd] : '0;
  end

  // Next-state, counter and buffer update logic; clr overrides everything.
  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_d      = wr_q;
    j_d       = j_q;
    pass_d    = pass_q;
    rd_d      = rd_q;
    swapped_d = swapped_q;

    case (state_q)
      LOAD: begin
        if (in_valid) begin
          mem_d[idx_wr] = in_data;
          if (wr_q == LAST_IDX) begin
            state_d   = SORT;
            wr_d      = '0;
            j_d       = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
          end else begin
            wr_d = wr_q + ONE;
          end
        end
      end
      SORT: begin
        // Only a strict greater-than swaps, which keeps equal values stable.
        if (cmp_res.gt) begin
          mem_d[idx_a] = mem_q[idx_b];
          mem_d[idx_b] = mem_q[idx_a];
        end
        if (j_q == LAST_J) begin
          if (!(swapped_q || cmp_res.gt) || (pass_q == LAST_PASS)) begin
            state_d   = DRAIN;
            j_d       = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
          end else begin
            pass_d    = pass_q + ONE;
            j_d       = '0;
            swapped_d = 1'b0;
          end
        end else begin
          j_d       = j_p1;
          swapped_d = swapped_q | cmp_res.gt;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rd_q == LAST_IDX) begin
            state_d = LOAD;
            rd_d    = '0;
          end else begin
            rd_d = rd_q + ONE;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    if (clr) begin
      state_d   = LOAD;
      mem_d     = mem_q;
      wr_d      = '0;
      j_d       = '0;
      pass_d    = '0;
      rd_d      = '0;
      swapped_d = 1'b0;
    end
  end

  // State, counter and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      wr_q      <= '0;
      j_q       <= '0;
      pass_q    <= '0;
      rd_q      <= '0;
      swapped_q <= 1'b0;
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      j_q       <= j_d;
      pass_q    <= pass_d;
      rd_q      <= rd_d;
      swapped_q <= swapped_d;
      mem_q     <= mem_d;
    end
  end

  // The comparator's equal and less-than decisions must never coincide.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(cmp_res.eq && cmp_res.lt));
  end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Directed testbench for cmp_sort_ctrl (N=4, W=5).
module tb_cmp_sort_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic       out_last;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  cmp_sort_ctrl #(.N(4), .W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] c, input logic [4:0] d);
    logic [4:0] v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_sort(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      step();
    end
  endtask

  task automatic drain4(input bit bp, output logic [19:0] dv, output logic [3:0] lastv,
                        output int got, output int unstable);
    logic [4:0] held_d;
    logic       held_l;
    bit         holding;
    int         guard;
    dv = '0; lastv = '0; got = 0; unstable = 0; holding = 0; guard = 0;
    while (got < 4 && guard < 200) begin
      guard++;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (holding && (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l))
        unstable++;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          dv[got*5 +: 5] = out_data;
          lastv[got]     = out_last;
          got++;
          holding = 0;
        end else begin
          held_d  = out_data;
          held_l  = out_last;
          holding = 1;
        end
      end
      step();
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    checks++; if (out_data !== 5'd0) begin failures++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
  endtask

  task automatic test_sorted();
    int cyc, got, uns; logic [19:0] dv; logic [3:0] lv;
    load4(5'd1, 5'd2, 5'd3, 5'd4);
    wait_sort(cyc);
    checks++; if (cyc != 3) begin failures++; $display("FAIL sorted_busy_cycles got=%0d want=3", cyc); end
    drain4(1'b0, dv, lv, got, uns);
    checks++; if (dv !== {5'd4, 5'd3, 5'd2, 5'd1}) begin failures++; $display("FAIL sorted_data got=%h want=%h", dv, {5'd4, 5'd3, 5'd2, 5'd1}); end
    checks++; if (lv !== 4'b1000) begin failures++; $display("FAIL sorted_last got=%b want=1000", lv); end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL sorted_back_to_load in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_reverse();
    int cyc, got, uns; logic [19:0] dv; logic [3:0] lv;
    load4(5'd31, 5'd20, 5'd7, 5'd0);
    wait_sort(cyc);
    checks++; if (cyc != 9) begin failures++; $display("FAIL reverse_busy_cycles got=%0d want=9", cyc); end
    drain4(1'b0, dv, lv, got, uns);
    checks++; if (dv !== {5'd31, 5'd20, 5'd7, 5'd0}) begin failures++; $display("FAIL reverse_data got=%h want=%h", dv, {5'd31, 5'd20, 5'd7, 5'd0}); end
    checks++; if (lv !== 4'b1000) begin failures++; $display("FAIL reverse_last got=%b want=1000", lv); end
  endtask

  task automatic test_duplicates();
    int cyc, got, uns; logic [19:0] dv; logic [3:0] lv;
    load4(5'd5, 5'd5, 5'd3, 5'd5);
    wait_sort(cyc);
    checks++; if (cyc != 9) begin failures++; $display("FAIL dup_busy_cycles got=%0d want=9", cyc); end
    drain4(1'b0, dv, lv, got, uns);
    checks++; if (dv !== {5'd5, 5'd5, 5'd5, 5'd3}) begin failures++; $display("FAIL dup_data got=%h want=%h", dv, {5'd5, 5'd5, 5'd5, 5'd3}); end
  endtask

  task automatic test_boundary();
    int cyc, got, uns; logic [19:0] dv; logic [3:0] lv;
    load4(5'd0, 5'd31, 5'd0, 5'd31);
    wait_sort(cyc);
    checks++; if (cyc != 6) begin failures++; $display("FAIL boundary_busy_cycles got=%0d want=6", cyc); end
    drain4(1'b0, dv, lv, got, uns);
    checks++; if (dv !== {5'd31, 5'd31, 5'd0, 5'd0}) begin failures++; $display("FAIL boundary_data got=%h want=%h", dv, {5'd31, 5'd31, 5'd0, 5'd0}); end
  endtask

  task automatic test_backpressure();
    int cyc, got, uns; logic [19:0] dv; logic [3:0] lv;
    load4(5'd12, 5'd3, 5'd25, 5'd3);
    in_valid = 1'b1;
    in_data  = 5'd31;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_sort got=%b want=0", in_ready); end
    wait_sort(cyc);
    drain4(1'b1, dv, lv, got, uns);
    in_valid = 1'b0;
    checks++; if (got != 4) begin failures++; $display("FAIL bp_word_count got=%0d want=4", got); end
    checks++; if (dv !== {5'd25, 5'd12, 5'd3, 5'd3}) begin failures++; $display("FAIL bp_data got=%h want=%h", dv, {5'd25, 5'd12, 5'd3, 5'd3}); end
    checks++; if (lv !== 4'b1000) begin failures++; $display("FAIL bp_last got=%b want=1000", lv); end
    checks++; if (uns != 0) begin failures++; $display("FAIL bp_hold_stable got=%0d unstable cycles want=0", uns); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_after got=%b want=1", in_ready); end
  endtask

  task automatic test_abort();
    int cyc, got, uns; logic [19:0] dv; logic [3:0] lv;
    load4(5'd10, 5'd20, 5'd30, 5'd1);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL abort_state in_ready=%b busy=%b out_valid=%b want 1/0/0", in_ready, busy, out_valid);
    end
    load4(5'd9, 5'd8, 5'd7, 5'd6);
    wait_sort(cyc);
    checks++; if (cyc != 9) begin failures++; $display("FAIL abort_busy_cycles got=%0d want=9", cyc); end
    drain4(1'b0, dv, lv, got, uns);
    checks++; if (dv !== {5'd9, 5'd8, 5'd7, 5'd6}) begin failures++; $display("FAIL abort_data got=%h want=%h", dv, {5'd9, 5'd8, 5'd7, 5'd6}); end
  endtask

  task automatic test_reset_mid_sort();
    int cyc, got, uns; logic [19:0] dv; logic [3:0] lv;
    load4(5'd31, 5'd20, 5'd7, 5'd0);
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 5'd0) begin
      failures++; $display("FAIL rst_mid_sort in_ready=%b busy=%b out_valid=%b out_last=%b out_data=%0d want 1/0/0/0/0",
                           in_ready, busy, out_valid, out_last, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    load4(5'd2, 5'd1, 5'd4, 5'd3);
    wait_sort(cyc);
    drain4(1'b0, dv, lv, got, uns);
    checks++; if (dv !== {5'd4, 5'd3, 5'd2, 5'd1}) begin failures++; $display("FAIL rst_recover_data got=%h want=%h", dv, {5'd4, 5'd3, 5'd2, 5'd1}); end
  endtask

  initial begin
    test_reset();
    test_sorted();
    test_reverse();
    test_duplicates();
    test_boundary();
    test_backpressure();
    test_abort();
    test_reset_mid_sort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmp_sort_ctrl.md
# cmp_sort_ctrl

Sequencing controller that time-shares a single 5-bit magnitude comparator to sort a small buffer of unsigned values. Values stream in over a valid/ready handshake, are bubble-sorted in place with one comparison per cycle, and stream out in ascending order. It is the scheduler that turns the team's combinational equal/greater/less comparator into a reusable sorting resource for downstream min/max and ranking logic.

## Interface
- `N`, 4: number of buffer entries; legal 2..16.
- `W`, 5: value width in bits; fixed by the comparator. Any other value is a configuration error.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: reset. Asynchronous assertion, active-low.
- `clr` input 1: synchronous abort. Returns the block to LOAD and discards the buffer contents logically.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the block accepts a word this cycle.
- `in_data` input W: unsigned value to load.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: the consumer accepts the word this cycle.
- `out_data` output W: sorted value, ascending order.
- `out_last` output 1: marks the final (N-th) output word.
- `busy` output 1: high while in SORT.

## Operation
- The FSM has three states.
  - LOAD: `in_ready`=1. Each accepted word (`in_valid` & `in_ready`) writes `buf[wr]` and increments `wr`. When the accepted word has `wr`==N-1, the next state is SORT, `wr` is cleared, and `j`, `pass` and `swapped` are cleared.
  - SORT: `busy`=1 and `in_ready`=0. Each cycle feeds `buf[j]` (A) and `buf[j+1]` (B) to the comparator.
    - If AgtB, the two entries swap that edge and `swapped` is set.
    - If AeqB or AltB, there is no swap, so the sort is stable.
    - At `j`==N-2, the pass ends. If no swap occurred during the pass (including this cycle), or `pass`==N-2, the next state is DRAIN. Otherwise `pass` increments and `j`, `swapped` return to 0.
    - Otherwise `j` increments.
  - DRAIN: `out_valid`=1 and `out_data`=`buf[rd]`. `out_last`=1 when `rd`==N-1. Each handshake increments `rd`. On the handshake of the last word, the next state is LOAD and `rd` is cleared.
- `in_valid` outside LOAD is ignored; no word is consumed.
- `out_data`, `out_last` and `out_valid` are held stable while `out_ready`=0.
- `clr` has priority over every transition. The next state is LOAD, all counters and flags clear, `out_valid` falls next cycle, and buffer contents are don't-care.
- Arithmetic:
  - Comparison is unsigned, W bits.
  - Counters are sized $clog2(N)+1 and never wrap beyond their terminal values.
  - Swaps use the registered buffer only; no forwarding is needed.

## Timing
- Reset values:
  - Outputs: `in_ready`=1, `out_valid`=0, `out_last`=0, `busy`=0, `out_data`=0.
  - Internal: state=LOAD, all buffer entries 0, all counters 0.
- Load takes N accepted handshakes. SORT is entered the cycle after the N-th accept.
- SORT duration:
  - Minimum N-1 cycles, for input already sorted.
  - Maximum (N-1)² cycles, for reverse order. For N=4 that is 3 to 9 cycles.
- The first `out_valid` is asserted the cycle after the last SORT cycle. With `out_ready` held high, drain takes N cycles.
- `in_ready` rises the cycle after the last output handshake, so a new load cannot overlap the drain.
- `rst_n` asserted mid-operation forces the reset values immediately, asynchronously.
- `clr` asserted on the same cycle as a handshake: `clr` wins. On the input side, that word is not written. On the output side, the handshake is accepted by the consumer but `rd` does not advance.

## Structure
- Shared package `cmp_pkg` holds:
  - the width constant W=5;
  - the state enum {LOAD, SORT, DRAIN};
  - the comparator result struct {eq, gt, lt}.
- Sub-module `mag_cmp5`: the combinational 5-bit comparator with one-hot outputs AeqB/AgtB/AltB, instantiated once. The controller uses only the `gt` decision to swap; `eq` and `lt` are checked by an assertion to be mutually exclusive.
- The buffer is a register array. Read muxes are indexed by `j`, `j+1` and `rd`.

## Test plan
- Reset: hold `rst_n`=0, then release. Required: `in_ready`=1, `out_valid`=0, `busy`=0, `out_last`=0, `out_data`=0.
- Sorted input 1,2,3,4, `out_ready`=1. Required: `busy` high for exactly 3 cycles, then outputs 1,2,3,4 with `out_last` on the 4th.
- Reverse input 31,20,7,0. Required: `busy` for 9 cycles, outputs 0,7,20,31.
- Duplicates 5,5,3,5. Required: outputs 3,5,5,5.
- Boundary values 0,31,0,31. Required: outputs 0,0,31,31.
- Backpressure and ignored input: toggle `out_ready` randomly during DRAIN and drive `in_valid`=1 throughout SORT and DRAIN. Required: no output lost or duplicated, and the buffer is unchanged by the ignored inputs.
- Abort mid-sort: apply `clr` in the 2nd SORT cycle, then load 9,8,7,6. Required: outputs 6,7,8,9.
- Reset mid-sort: assert `rst_n` in the 2nd SORT cycle. Required: all outputs return to reset values immediately.
